// File: rtl/audio_const_axil_slave.sv
// AXI4-Lite slave holding four 32-bit audio constants for the pitch-training datapath.
// Define AUDIO_CONST_SHADOW_EN to latch const0..3 only on frame_sync edges.
module audio_const_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic                              frame_sync,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     const0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     const1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     const2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     const3,
  output logic [3:0]                        reg_wr_pulse
);

  localparam int NUM_REGS  = 4;
  localparam int DW        = C_S_AXI_DATA_WIDTH;
  localparam int NUM_BYTES = DW / 8;

  logic                 aw_held_reg, aw_held_next;
  logic [1:0]           aw_idx_reg;
  logic                 w_held_reg, w_held_next;
  logic [DW-1:0]        w_data_reg;
  logic [NUM_BYTES-1:0] w_strb_reg;
  logic                 awready_reg, wready_reg;
  logic                 bvalid_reg, bvalid_next;
  logic                 arready_reg;
  logic                 rvalid_reg, rvalid_next;
  logic [DW-1:0]        rdata_reg;
  logic [3:0]           pulse_reg;

  logic                 aw_hs, w_hs, ar_hs, commit;
  logic [3:0]           wr_sel;
  logic [DW-1:0]        reg_val   [NUM_REGS];
  logic [DW-1:0]        const_val [NUM_REGS];

  always_comb begin
    aw_hs  = s00_axi_awvalid && awready_reg;
    w_hs   = s00_axi_wvalid  && wready_reg;
    ar_hs  = s00_axi_arvalid && arready_reg;
    commit = aw_held_reg && w_held_reg && !bvalid_reg;

    aw_held_next = aw_held_reg;
    if (commit)
      aw_held_next = 1'b0;
    else if (aw_hs)
      aw_held_next = 1'b1;

    w_held_next = w_held_reg;
    if (commit)
      w_held_next = 1'b0;
    else if (w_hs)
      w_held_next = 1'b1;

    bvalid_next = bvalid_reg;
    if (commit)
      bvalid_next = 1'b1;
    else if (bvalid_reg && s00_axi_bready)
      bvalid_next = 1'b0;

    rvalid_next = rvalid_reg;
    if (ar_hs)
      rvalid_next = 1'b1;
    else if (rvalid_reg && s00_axi_rready)
      rvalid_next = 1'b0;
  end

  // Ready flags are registered from next-state so they drop on the handshake edge.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_held_reg <= 1'b0;
      aw_idx_reg  <= '0;
      w_held_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      pulse_reg   <= '0;
    end else begin
      aw_held_reg <= aw_held_next;
      w_held_reg  <= w_held_next;
      bvalid_reg  <= bvalid_next;
      rvalid_reg  <= rvalid_next;
      awready_reg <= !aw_held_next && !bvalid_next;
      wready_reg  <= !w_held_next && !bvalid_next;
      arready_reg <= !rvalid_next;
      pulse_reg   <= wr_sel;
      if (aw_hs)
        aw_idx_reg <= s00_axi_awaddr[3:2];
      if (w_hs) begin
        w_data_reg <= s00_axi_wdata;
        w_strb_reg <= s00_axi_wstrb;
      end
      if (ar_hs)
        rdata_reg <= reg_val[s00_axi_araddr[3:2]];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DW-1:0] value_reg;

      assign wr_sel[gi]  = commit && (aw_idx_reg == 2'(gi));
      assign reg_val[gi] = value_reg;

      always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
          value_reg <= '0;
        end else if (wr_sel[gi]) begin
          for (int k = 0; k < NUM_BYTES; k++) begin
            if (w_strb_reg[k])
              value_reg[8*k +: 8] <= w_data_reg[8*k +: 8];
          end
        end
      end

`ifdef AUDIO_CONST_SHADOW_EN
      // Shadow copy moves only at frame boundaries so a frame never sees a torn update.
      logic [DW-1:0] shadow_reg;

      always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn)
          shadow_reg <= '0;
        else if (frame_sync)
          shadow_reg <= value_reg;
      end

      assign const_val[gi] = shadow_reg;
`else
      assign const_val[gi] = value_reg;
`endif
    end
  endgenerate

  assign s00_axi_awready = awready_reg;
  assign s00_axi_wready  = wready_reg;
  assign s00_axi_bvalid  = bvalid_reg;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_reg;
  assign s00_axi_rvalid  = rvalid_reg;
  assign s00_axi_rdata   = rdata_reg;
  assign s00_axi_rresp   = 2'b00;
  assign reg_wr_pulse    = pulse_reg;

  assign const0 = const_val[0];
  assign const1 = const_val[1];
  assign const2 = const_val[2];
  assign const3 = const_val[3];

  // Sub-word address bits and protection attributes carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0], frame_sync};

endmodule

// File: tb/tb_audio_const_axil_slave.sv
// Self-checking bench for audio_const_axil_slave: vector table plus hand-written corner sequences.
module tb_audio_const_axil_slave;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        frame_sync;
  logic [31:0] const0, const1, const2, const3;
  logic [3:0]  reg_wr_pulse;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  audio_const_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .frame_sync(frame_sync),
    .const0(const0), .const1(const1), .const2(const2), .const3(const3),
    .reg_wr_pulse(reg_wr_pulse)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    tot_cnt++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic frame_pulse();
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  // Write with W optionally presented w_lead cycles ahead of AW; B held off for bhold cycles.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int bhold, input int w_lead);
    logic aw_go, w_go;
    int   n;
    logic [3:0] exp_pulse;
    exp_pulse = 4'b0001 << addr[3:2];
    awaddr = addr; wdata = data; wstrb = strb; bready = 1'b0;
    wvalid = 1'b1;
    for (int i = 0; i < w_lead; i++) begin
      w_go = wvalid && wready;
      @(negedge clk);
      if (w_go) wvalid = 1'b0;
    end
    if (w_lead > 0) begin
      chk("w_held_wready", {31'b0, wready}, 32'd0);
      chk("w_held_awready", {31'b0, awready}, 32'd1);
    end
    awvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk);
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
      n++;
    end
    if (awvalid || wvalid) begin
      timeout("aw_w_handshake");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) begin
      timeout("bvalid");
      return;
    end
    chk($sformatf("wr_pulse@%h", addr), {28'b0, reg_wr_pulse}, {28'b0, exp_pulse});
    chk("bresp", {30'b0, bresp}, 32'd0);
    for (int i = 0; i < bhold; i++) begin
      @(negedge clk);
      chk("bvalid_hold", {31'b0, bvalid}, 32'd1);
      chk("ready_hold", {30'b0, awready, wready}, 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_clr", {31'b0, bvalid}, 32'd0);
    chk("pulse_clr", {28'b0, reg_wr_pulse}, 32'd0);
    chk("ready_back", {30'b0, awready, wready}, 32'd3);
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input int rhold);
    logic        go;
    int          n;
    logic [31:0] want;
    exp_q.push_back(exp);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (arvalid && n < 50) begin
      go = arvalid && arready;
      @(negedge clk);
      if (go) arvalid = 1'b0;
      n++;
    end
    if (arvalid) begin
      timeout("ar_handshake");
      arvalid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    want = exp_q.pop_front();
    if (!rvalid) begin
      timeout("rvalid");
      return;
    end
    chk($sformatf("rdata@%h", addr), rdata, want);
    chk("rresp", {30'b0, rresp}, 32'd0);
    for (int i = 0; i < rhold; i++) begin
      @(negedge clk);
      chk("rdata_stable", rdata, want);
      chk("arready_low", {31'b0, arready}, 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rvalid_clr", {31'b0, rvalid}, 32'd0);
    chk("arready_back", {31'b0, arready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'h0, 32'h1,        4'hF, 0, 32'h0};
    vecs[1]  = '{1'b1, 4'h4, 32'h2,        4'hF, 0, 32'h0};
    vecs[2]  = '{1'b1, 4'h8, 32'h3,        4'hF, 0, 32'h0};
    vecs[3]  = '{1'b1, 4'hC, 32'h4,        4'hF, 0, 32'h0};
    vecs[4]  = '{1'b0, 4'h0, 32'h0,        4'h0, 0, 32'h1};
    vecs[5]  = '{1'b0, 4'h4, 32'h0,        4'h0, 2, 32'h2};
    vecs[6]  = '{1'b0, 4'h8, 32'h0,        4'h0, 0, 32'h3};
    vecs[7]  = '{1'b0, 4'hC, 32'h0,        4'h0, 0, 32'h4};
    vecs[8]  = '{1'b1, 4'h4, 32'hFFFFFFFF, 4'hF, 0, 32'h0};
    vecs[9]  = '{1'b1, 4'h5, 32'h00000000, 4'h5, 0, 32'h0};
    vecs[10] = '{1'b0, 4'h6, 32'h0,        4'h0, 1, 32'hFF00FF00};
    vecs[11] = '{1'b1, 4'h8, 32'hAAAAAAAA, 4'h0, 0, 32'h0};
    vecs[12] = '{1'b0, 4'h8, 32'h0,        4'h0, 0, 32'h3};

    aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0; frame_sync = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_readies", {29'b0, awready, wready, arready}, 32'd0);
    chk("rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_const0", const0, 32'd0);
    chk("rst_pulse", {28'b0, reg_wr_pulse}, 32'd0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("post_rst_readies", {29'b0, awready, wready, arready}, 32'd7);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].hold, 0);
      else            do_read(vecs[i].addr, vecs[i].exp, vecs[i].hold);
      $display("vec %0d: %s addr=0x%h data=0x%08h strb=%b", i, vecs[i].wr ? "WR" : "RD",
               vecs[i].addr, vecs[i].wr ? vecs[i].data : vecs[i].exp, vecs[i].strb);
    end
    frame_pulse();
    chk("const1_after_table", const1, 32'hFF00FF00);
    chk("const3_after_table", const3, 32'h4);

    // W leads AW by three cycles, then B stalled five cycles.
    do_write(4'h8, 32'hDEADBEEF, 4'hF, 5, 3);
    frame_pulse();
    chk("const2_deadbeef", const2, 32'hDEADBEEF);
    $display("seq W-before-AW: addr=0x8 data=0xDEADBEEF");

    // AR handshake on the same edge as a commit to the same register.
    @(negedge clk);
    chk("pre_collide_readies", {29'b0, awready, wready, arready}, 32'd7);
    awaddr = 4'h4; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 4'h4; arvalid = 1'b1; exp_q.push_back(32'hFF00FF00);
    @(negedge clk);
    arvalid = 1'b0;
    chk("collide_valids", {30'b0, rvalid, bvalid}, 32'd3);
    chk("collide_pulse", {28'b0, reg_wr_pulse}, 32'h2);
    if (exp_q.size() > 0) chk("collide_rdata_old", rdata, exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("collide_rdata_stable", rdata, 32'hFF00FF00);
      chk("collide_arready_low", {31'b0, arready}, 32'd0);
    end
    chk("collide_b_done", {31'b0, bvalid}, 32'd0);
    bready = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("collide_rvalid_clr", {31'b0, rvalid}, 32'd0);
    do_read(4'h4, 32'h55, 0);
    $display("seq read/commit collision: old=0xFF00FF00 new=0x00000055");

    // Reset asserted while AW is held and W never arrived.
    awaddr = 4'h0; awvalid = 1'b1;
    begin
      int n;
      n = 0;
      while (!awready && n < 20) begin @(negedge clk); n++; end
    end
    @(negedge clk);
    awvalid = 1'b0;
    chk("aw_held_awready", {31'b0, awready}, 32'd0);
    aresetn = 1'b0;
    #1;
    chk("async_rst_const1", const1, 32'd0);
    chk("async_rst_readies", {29'b0, awready, wready, arready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    begin
      logic seen_b;
      seen_b = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        seen_b = seen_b | bvalid;
      end
      chk("no_b_after_rst", {31'b0, seen_b}, 32'd0);
    end
    for (int r = 0; r < 4; r++) begin
      logic [3:0] a;
      a = 4'(r * 4);
      do_read(a, 32'h0, 0);
    end
    frame_pulse();
    chk("rst_const2", const2, 32'd0);
    do_write(4'hC, 32'hCAFEF00D, 4'hF, 0, 0);
    do_read(4'hC, 32'hCAFEF00D, 0);
    $display("seq reset mid-write: regs cleared, write 0xC=0xCAFEF00D ok");

`ifdef AUDIO_CONST_SHADOW_EN
    do_write(4'h0, 32'h1234, 4'hF, 0, 0);
    chk("shadow_const0_hold", const0, 32'd0);
    do_read(4'h0, 32'h1234, 0);
    chk("shadow_const0_still", const0, 32'd0);
    frame_pulse();
    chk("shadow_const0_load", const0, 32'h1234);
`else
    do_write(4'h0, 32'h1234, 4'hF, 0, 0);
    chk("const0_direct", const0, 32'h1234);
    do_read(4'h0, 32'h1234, 0);
`endif
    $display("seq const0 update: 0x1234");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/audio_const_axil_slave.md
Name: audio_const_axil_slave

Overview:
AXI4-Lite responder (slave) exposing four 32-bit read/write audio constant registers to the PS/MicroBlaze master. It is the target of the sequential write-then-readback bus traffic used in the audio_const example design. Register values drive the pitch-training datapath (reference pitch, thresholds, gain, mode). Sits between the AXI interconnect and the audio processing logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects the register, addr[1:0] is ignored.

Ports:
s00_axi_aclk  in  1  clock, rising edge.
s00_axi_aresetn  in  1  asynchronous active-low reset.
s00_axi_awaddr  in  4  write address.
s00_axi_awprot  in  3  ignored.
s00_axi_awvalid / s00_axi_awready  in/out  1  write address handshake.
s00_axi_wdata  in  32  write data.
s00_axi_wstrb  in  4  byte enables.
s00_axi_wvalid / s00_axi_wready  in/out  1  write data handshake.
s00_axi_bresp  out  2  write response, always 2'b00 (OKAY).
s00_axi_bvalid / s00_axi_bready  out/in  1  write response handshake.
s00_axi_araddr  in  4  read address.
s00_axi_arprot  in  3  ignored.
s00_axi_arvalid / s00_axi_arready  in/out  1  read address handshake.
s00_axi_rdata  out  32  read data.
s00_axi_rresp  out  2  always 2'b00.
s00_axi_rvalid / s00_axi_rready  out/in  1  read data handshake.
frame_sync  in  1  one-cycle audio frame strobe; used only with the optional feature.
const0..const3  out  32 each  register values presented to the audio datapath.
reg_wr_pulse  out  4  one-cycle pulse, bit n set on the cycle after a commit to register n.

Behaviour:
- Reset (aresetn low, asynchronous): all ready/valid outputs 0, bresp/rresp 0, rdata 0, reg0..reg3 0, const0..3 0, reg_wr_pulse 0, holding flags clear. Outputs are held while reset is asserted. Any transaction in flight is discarded and produces no response.
- Write path:
  - AW and W are accepted independently, in either order or in the same cycle. Each goes into a one-entry holding register with a valid flag.
  - awready = !aw_held && !bvalid. wready = !w_held && !bvalid. Both are registered and deasserted the cycle after their handshake.
  - Commit happens on the first edge where both are held and bvalid=0. Each byte lane with wstrb[k]=1 is written into reg[awaddr[3:2]]. Holding flags clear, bvalid rises on the same edge, and reg_wr_pulse[n] is high for that one cycle.
  - bvalid holds until bready. A new AW/W is accepted from the cycle after B completes. Only one write is outstanding at a time.
  - wstrb=0 commits nothing but still produces an OKAY response and a pulse.
- Read path:
  - arready = !rvalid.
  - On the AR handshake edge, rdata is loaded with reg[araddr[3:2]] and rvalid rises, giving 1-cycle latency.
  - rdata and rvalid are stable until rready. arready returns in the cycle after R completes.
- Simultaneous read and write commit to the same register on the same edge: the read returns the pre-write value.
- Addresses 0x0, 0x4, 0x8 and 0xC map to reg0..reg3. Unaligned addresses alias to the word; there is no SLVERR.
- Readback always returns reg0..reg3, the AXI-side values.

Optional Feature:
AUDIO_CONST_SHADOW_EN
- Defined: const0..3 are shadow registers, loaded from reg0..reg3 only on edges where frame_sync=1. This keeps mid-frame updates from tearing. A commit and frame_sync on the same edge propagate the old value; the new value reaches const on the next frame_sync. Shadows reset to 0.
- Undefined: const0..3 are continuous assigns of reg0..reg3 and frame_sync is ignored.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then read all four -> rdata 0x1..0x4, every bresp/rresp = 0, reg_wr_pulse shows bits 0..3 in order.
- W presented 3 cycles before AW at 0x8, data 0xDEADBEEF, then bready held low 5 cycles -> bvalid stays high and awready/wready stay low until bready; const2 = 0xDEADBEEF.
- reg1 = 0xFFFFFFFF, then write 0x00000000 with wstrb=4'b0101 -> readback 0xFF00FF00.
- Read 0x4 with rready low 4 cycles -> rdata stable, arready low. In the same cycle as the AR handshake, commit 0x55 to 0x4 -> first read returns the old value, a second read returns 0x55.
- Assert aresetn low mid-write (AW held, W not yet sent) -> no bvalid after release, all regs 0. A subsequent write to 0xC completes normally.
- With AUDIO_CONST_SHADOW_EN: write 0x1234 to 0x0 -> const0 stays 0 until frame_sync, then becomes 0x1234. Readback shows 0x1234 immediately.
